// File: rtl/fetch_unit.sv
// Instruction fetch and decode front end: walks a byte-wide instruction memory,
// skips NOPs, assembles two-byte MOVI instructions and hands out one decoded instruction at a time.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pc_addr,
  input  logic [7:0] instr_in,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_opcode,
  output logic [1:0] out_rd,
  output logic [1:0] out_rs,
  output logic [7:0] out_imm,
  output logic [7:0] out_pc
);

  localparam logic [2:0] OP_MOVI = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] pc, pc_next;
  logic       valid_next;
  logic [2:0] opcode_next;
  logic [1:0] rd_next, rs_next;
  logic [7:0] imm_next, opc_pc_next;
  logic [2:0] op;
  logic       consume;

  assign op      = instr_in[7:5];
  assign pc_addr = pc;

  // A new opcode byte is taken in FETCH, or in HOLD on the same edge the held instruction leaves.
  assign consume = (state == FETCH) || ((state == HOLD) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_opcode <= 3'd0;
      out_rd     <= 2'd0;
      out_rs     <= 2'd0;
      out_imm    <= 8'd0;
      out_pc     <= 8'd0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      out_valid  <= valid_next;
      out_opcode <= opcode_next;
      out_rd     <= rd_next;
      out_rs     <= rs_next;
      out_imm    <= imm_next;
      out_pc     <= opc_pc_next;
    end
  end

  always_comb begin
    state_next = state;
    if (jump_en) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH_IMM: state_next = HOLD;
        FETCH, HOLD: begin
          if (consume) begin
            case (op)
              OP_NOP:  state_next = FETCH;
              OP_MOVI: state_next = FETCH_IMM;
              default: state_next = HOLD;
            endcase
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_next     = pc;
    valid_next  = out_valid;
    opcode_next = out_opcode;
    rd_next     = out_rd;
    rs_next     = out_rs;
    imm_next    = out_imm;
    opc_pc_next = out_pc;
    if (jump_en) begin
      // A redirect discards any partial or held instruction.
      pc_next    = jump_target;
      valid_next = 1'b0;
    end else if (state == FETCH_IMM) begin
      imm_next   = instr_in;
      pc_next    = pc + 8'd1;
      valid_next = 1'b1;
    end else if (consume) begin
      pc_next    = pc + 8'd1;
      valid_next = 1'b0;
      if (op != OP_NOP) begin
        opcode_next = op;
        rd_next     = instr_in[4:3];
        rs_next     = instr_in[2:1];
        opc_pc_next = pc;
        if (op != OP_MOVI) begin
          imm_next   = 8'd0;
          valid_next = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal scenarios followed by randomized programs,
// all checked every cycle against an instruction-level reference model.
module tb_fetch_unit;

  localparam logic [7:0] RPC = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pc_addr;
  logic [7:0] instr_in;
  logic       jump_en = 1'b0;
  logic [7:0] jump_target = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_opcode;
  logic [1:0] out_rd, out_rs;
  logic [7:0] out_imm, out_pc;

  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;

  // Reference model: which instruction is held, whether a MOVI awaits its immediate
  logic [7:0] m_pc = RPC;
  logic       m_have = 1'b0;
  logic       m_half = 1'b0;
  logic [2:0] m_op = 3'd0;
  logic [1:0] m_rd = 2'd0, m_rs = 2'd0;
  logic [7:0] m_imm = 8'd0, m_ipc = 8'd0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .instr_in(instr_in),
    .jump_en(jump_en), .jump_target(jump_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs(out_rs), .out_imm(out_imm), .out_pc(out_pc)
  );

  always #5 clk = ~clk;
  assign instr_in = mem[pc_addr];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_have <= 1'b0; m_half <= 1'b0;
      m_op <= 3'd0; m_rd <= 2'd0; m_rs <= 2'd0; m_imm <= 8'd0; m_ipc <= 8'd0;
    end else if (jump_en) begin
      m_pc <= jump_target; m_have <= 1'b0; m_half <= 1'b0;
    end else if (m_half) begin
      m_imm <= mem[m_pc]; m_pc <= m_pc + 8'd1; m_have <= 1'b1; m_half <= 1'b0;
    end else if (!m_have || out_ready) begin
      m_pc   <= m_pc + 8'd1;
      m_have <= 1'b0;
      if (mem[m_pc][7:5] != 3'b111) begin
        m_op  <= mem[m_pc][7:5];
        m_rd  <= mem[m_pc][4:3];
        m_rs  <= mem[m_pc][2:1];
        m_ipc <= m_pc;
        if (mem[m_pc][7:5] == 3'b100) m_half <= 1'b1;
        else begin m_imm <= 8'd0; m_have <= 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {7'd0, out_valid}, {7'd0, m_have});
    chk("model_pc_addr", pc_addr, m_pc);
    if (m_have) begin
      chk("model_opcode", {5'd0, out_opcode}, {5'd0, m_op});
      chk("model_rd", {6'd0, out_rd}, {6'd0, m_rd});
      chk("model_rs", {6'd0, out_rs}, {6'd0, m_rs});
      chk("model_imm", out_imm, m_imm);
      chk("model_out_pc", out_pc, m_ipc);
    end
  end

  // Reset pulse between edges; checks the asynchronous reset values before release.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_pc_addr", pc_addr, RPC);
    chk("rst_out_pc", out_pc, 8'd0);
    chk("rst_imm", out_imm, 8'd0);
    chk("rst_opcode", {5'd0, out_opcode}, 8'd0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;

    // Back-to-back one-byte instructions across the FF->00 wrap
    mem[8'hFF] = 8'h0A; mem[8'h00] = 8'h34; out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("b2b_valid0", {7'd0, out_valid}, 8'd1);
    chk("b2b_op0", {5'd0, out_opcode}, 8'd0);
    chk("b2b_rd0", {6'd0, out_rd}, 8'd1);
    chk("b2b_rs0", {6'd0, out_rs}, 8'd1);
    chk("b2b_pc0", out_pc, 8'hFF);
    @(negedge clk);
    chk("b2b_valid1", {7'd0, out_valid}, 8'd1);
    chk("b2b_op1", {5'd0, out_opcode}, 8'd1);
    chk("b2b_rd1", {6'd0, out_rd}, 8'd2);
    chk("b2b_pc1", out_pc, 8'h00);

    // MOVI with opcode at FF and immediate at 00
    mem[8'hFF] = 8'h88; mem[8'h00] = 8'h11; mem[8'h01] = 8'hE0;
    do_reset();
    @(negedge clk);
    chk("movi_wait", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    chk("movi_valid", {7'd0, out_valid}, 8'd1);
    chk("movi_op", {5'd0, out_opcode}, 8'd4);
    chk("movi_rd", {6'd0, out_rd}, 8'd1);
    chk("movi_imm", out_imm, 8'h11);
    chk("movi_pc", out_pc, 8'hFF);
    chk("movi_pc_addr", pc_addr, 8'h01);

    // NOPs are skipped
    mem[8'hFF] = 8'hE0; mem[8'h00] = 8'hE0; mem[8'h01] = 8'h0A; mem[8'h02] = 8'hE0;
    do_reset();
    @(negedge clk); chk("nop_v0", {7'd0, out_valid}, 8'd0);
    @(negedge clk); chk("nop_v1", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    chk("nop_v2", {7'd0, out_valid}, 8'd1);
    chk("nop_out_pc", out_pc, 8'h01);

    // Back-pressure holds everything; first ready cycle transfers once
    mem[8'hFF] = 8'h0A; mem[8'h00] = 8'hE0; mem[8'h01] = 8'hE0; out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {7'd0, out_valid}, 8'd1);
      chk("hold_pc_addr", pc_addr, 8'h00);
      chk("hold_out_pc", out_pc, 8'hFF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_xfer_once", {7'd0, out_valid}, 8'd0);
    chk("hold_xfer_pc", pc_addr, 8'h01);

    // Jump while waiting for a MOVI immediate
    mem[8'hFF] = 8'h88; mem[8'h40] = 8'hE0;
    do_reset();
    @(negedge clk);
    jump_en = 1'b1; jump_target = 8'h40;
    @(negedge clk);
    chk("jump_valid", {7'd0, out_valid}, 8'd0);
    chk("jump_pc_addr", pc_addr, 8'h40);
    jump_en = 1'b0;
    @(negedge clk);
    chk("jump_dropped", {7'd0, out_valid}, 8'd0);

    // Asynchronous reset while holding
    mem[8'hFF] = 8'h0A; out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("async_pre", {7'd0, out_valid}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {7'd0, out_valid}, 8'd0);
    chk("async_pc_addr", pc_addr, RPC);
    #1 rst_n = 1'b1;

    // Randomized programs against the model
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int c = 0; c < 500; c++) begin
        @(posedge clk); #2;
        out_ready   = ($urandom_range(0, 3) != 0);
        jump_en     = ($urandom_range(0, 15) == 0);
        jump_target = 8'($urandom);
        if ($urandom_range(0, 199) == 0) begin
          rst_n = 1'b0; #1; rst_n = 1'b1;
        end
      end
    end
    jump_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
